// File: rtl/bin2bcd_seq_if.sv
// Handshake/result bundle for the sequential binary-to-BCD converter.
//   start      request a conversion (seen only while the converter is idle)
//   binary_in  unsigned value to convert
//   busy       conversion in progress
//   done       one-cycle pulse, result valid from this cycle on
//   bcd_out    packed BCD digits, [3:0] = ones
//   overflow   last value did not fit in DIGITS digits
// The master drives start/binary_in; the slave (converter) drives the rest.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      binary_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;

  modport master (
    output start, binary_in,
    input  busy, done, bcd_out, overflow
  );

  modport slave (
    input  start, binary_in,
    output busy, done, bcd_out, overflow
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Results are registered and only updated on the done edge, so a display fed
// from bcd_out never sees intermediate values.
//   clk   system clock
//   rst   synchronous reset, active-high
//   bus   bin2bcd_seq_if slave: start, binary_in in; busy, done, bcd_out, overflow out
// Parameters:
//   WIDTH   binary input width
//   DIGITS  number of BCD digits produced
//   AUTO    1: also start whenever binary_in differs from the last converted value
//
// state | meaning
// IDLE  | waiting for start (or a changed input when AUTO=1)
// SHIFT | shifting one bit per clock, WIDTH clocks in total
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter bit AUTO   = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  bin2bcd_seq_if.slave bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   bin_sr, bin_sr_nxt;
  logic [WIDTH-1:0]   last_val, last_val_nxt;
  logic [BCD_W-1:0]   bcd_sr, bcd_sr_nxt;
  logic               ovf_sr, ovf_sr_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               busy_r, busy_nxt;
  logic               done_r, done_nxt;
  logic [BCD_W-1:0]   bcd_r, bcd_nxt;
  logic               ovf_r, ovf_nxt;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_shift;
  logic               ovf_shift;
  logic               go;

  always_comb begin
    // Digits <= 9 before adjust, so digit+3 stays <= 12 and never carries.
    bcd_adj = bcd_sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
      end
    end
  end

  // The MSB of the adjusted top digit is what leaves the BCD register on the
  // shift; a set bit there means the value needs more than DIGITS digits.
  assign bcd_shift = {bcd_adj[BCD_W-2:0], bin_sr[WIDTH-1]};
  assign ovf_shift = ovf_sr | bcd_adj[BCD_W-1];

  assign go = bus.start | (AUTO && (bus.binary_in != last_val));

  always_comb begin
    state_nxt    = state;
    bin_sr_nxt   = bin_sr;
    last_val_nxt = last_val;
    bcd_sr_nxt   = bcd_sr;
    ovf_sr_nxt   = ovf_sr;
    cnt_nxt      = cnt;
    busy_nxt     = busy_r;
    done_nxt     = 1'b0;
    bcd_nxt      = bcd_r;
    ovf_nxt      = ovf_r;

    case (state)
      IDLE: begin
        if (go) begin
          bin_sr_nxt   = bus.binary_in;
          last_val_nxt = bus.binary_in;
          bcd_sr_nxt   = '0;
          ovf_sr_nxt   = 1'b0;
          cnt_nxt      = '0;
          busy_nxt     = 1'b1;
          state_nxt    = SHIFT;
        end
      end
      SHIFT: begin
        bin_sr_nxt = bin_sr << 1;
        bcd_sr_nxt = bcd_shift;
        ovf_sr_nxt = ovf_shift;
        cnt_nxt    = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          bcd_nxt   = bcd_shift;
          ovf_nxt   = ovf_shift;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bin_sr   <= '0;
      last_val <= '0;
      bcd_sr   <= '0;
      ovf_sr   <= 1'b0;
      cnt      <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      bcd_r    <= '0;
      ovf_r    <= 1'b0;
    end else begin
      state    <= state_nxt;
      bin_sr   <= bin_sr_nxt;
      last_val <= last_val_nxt;
      bcd_sr   <= bcd_sr_nxt;
      ovf_sr   <= ovf_sr_nxt;
      cnt      <= cnt_nxt;
      busy_r   <= busy_nxt;
      done_r   <= done_nxt;
      bcd_r    <= bcd_nxt;
      ovf_r    <= ovf_nxt;
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.bcd_out  = bcd_r;
  assign bus.overflow = ovf_r;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: three instances (8-bit manual start, 8-bit auto
// start, 10-bit manual start with overflow). Inputs change and outputs are
// sampled on the falling edge.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bin2bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) bus0 ();
  bin2bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) bus1 ();
  bin2bcd_seq_if #(.WIDTH(10), .DIGITS(3)) bus2 ();

  bin2bcd_seq #(.WIDTH(8),  .DIGITS(3), .AUTO(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  bin2bcd_seq #(.WIDTH(8),  .DIGITS(3), .AUTO(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  bin2bcd_seq #(.WIDTH(10), .DIGITS(3), .AUTO(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          val;
    logic [11:0] bcd;
    logic        ovf;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    logic [11:0] r;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 10);
    return r;
  endfunction

  task automatic drive(input int sel, input logic s, input int v);
    if (sel == 0) begin
      bus0.start = s; bus0.binary_in = v[7:0];
    end else begin
      bus2.start = s; bus2.binary_in = v[9:0];
    end
  endtask

  function automatic logic get_done(input int sel);
    return (sel == 0) ? bus0.done : bus2.done;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? bus0.busy : bus2.busy;
  endfunction

  function automatic logic [11:0] get_bcd(input int sel);
    return (sel == 0) ? bus0.bcd_out : bus2.bcd_out;
  endfunction

  function automatic logic get_ovf(input int sel);
    return (sel == 0) ? bus0.overflow : bus2.overflow;
  endfunction

  // Pulses start for one cycle; lat counts falling edges after the accepting
  // edge until done is seen (bounded). held_bad counts bcd_out changes while busy.
  task automatic run_conv(input int sel, input int val, output int lat,
                          output int busy_cycles, output int held_bad);
    logic [11:0] pre;
    pre = get_bcd(sel);
    drive(sel, 1'b1, val);
    @(negedge clk);
    drive(sel, 1'b0, val);
    lat = 0; busy_cycles = 0; held_bad = 0;
    while (!get_done(sel) && lat < 40) begin
      if (get_busy(sel)) busy_cycles++;
      if (get_bcd(sel) != pre) held_bad++;
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t vecs[12];
  int lat, bc, hb, d, done_at;

  initial begin
    vecs[0]  = '{255, 12'h255, 1'b0};
    vecs[1]  = '{0,   12'h000, 1'b0};
    vecs[2]  = '{1,   12'h001, 1'b0};
    vecs[3]  = '{5,   12'h005, 1'b0};
    vecs[4]  = '{9,   12'h009, 1'b0};
    vecs[5]  = '{10,  12'h010, 1'b0};
    vecs[6]  = '{50,  12'h050, 1'b0};
    vecs[7]  = '{59,  12'h059, 1'b0};
    vecs[8]  = '{99,  12'h099, 1'b0};
    vecs[9]  = '{100, 12'h100, 1'b0};
    vecs[10] = '{128, 12'h128, 1'b0};
    vecs[11] = '{200, 12'h200, 1'b0};

    rst = 1'b1;
    bus0.start = 1'b0; bus0.binary_in = '0;
    bus1.start = 1'b0; bus1.binary_in = '0;
    bus2.start = 1'b0; bus2.binary_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset_busy", int'(bus0.busy), 0);
    check("reset_done", int'(bus0.done), 0);
    check("reset_bcd", int'(bus0.bcd_out), 0);
    check("reset_ovf", int'(bus0.overflow), 0);
    check("reset_bcd_w10", int'(bus2.bcd_out), 0);

    // Directed table, manual start.
    for (int i = 0; i < 12; i++) begin
      run_conv(0, vecs[i].val, lat, bc, hb);
      check($sformatf("tbl_lat_%0d", vecs[i].val), lat, 8);
      check($sformatf("tbl_busy_%0d", vecs[i].val), bc, 8);
      check($sformatf("tbl_held_%0d", vecs[i].val), hb, 0);
      check($sformatf("tbl_bcd_%0d", vecs[i].val), int'(bus0.bcd_out), int'(vecs[i].bcd));
      check($sformatf("tbl_ovf_%0d", vecs[i].val), int'(bus0.overflow), int'(vecs[i].ovf));
      @(negedge clk);
      check($sformatf("tbl_done_width_%0d", vecs[i].val), int'(bus0.done), 0);
    end

    // Exhaustive sweep against a decimal reference.
    for (int v = 0; v < 256; v++) begin
      run_conv(0, v, lat, bc, hb);
      check($sformatf("sweep_lat_%0d", v), lat, 8);
      check($sformatf("sweep_bcd_%0d", v), int'(bus0.bcd_out), int'(ref_bcd(v)));
    end

    // In-flight start ignored, then back-to-back start in the done cycle.
    drive(0, 1'b1, 99);
    @(negedge clk);
    drive(0, 1'b0, 99);
    d = 0; done_at = -1;
    for (int k = 0; k <= 8; k++) begin
      if (bus0.done) begin
        d++;
        done_at = k;
        check("inflight_bcd", int'(bus0.bcd_out), 12'h099);
      end
      if (k == 4) drive(0, 1'b1, 7);
      if (k == 5) drive(0, 1'b0, 7);
      if (k == 8) drive(0, 1'b1, 7);
      @(negedge clk);
    end
    drive(0, 1'b0, 7);
    check("inflight_dones", d, 1);
    check("inflight_done_at", done_at, 8);
    d = 0; done_at = -1;
    for (int k = 0; k <= 8; k++) begin
      if (bus0.done) begin
        d++;
        done_at = k;
        check("b2b_bcd", int'(bus0.bcd_out), 12'h007);
      end
      @(negedge clk);
    end
    check("b2b_dones", d, 1);
    check("b2b_done_at", done_at, 8);
    d = 0;
    repeat (12) begin
      if (bus0.done) d++;
      @(negedge clk);
    end
    check("no_spurious_done", d, 0);

    // Reset in the middle of converting 200.
    drive(0, 1'b1, 200);
    @(negedge clk);
    drive(0, 1'b0, 200);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", int'(bus0.busy), 0);
    check("midrst_bcd", int'(bus0.bcd_out), 0);
    check("midrst_done", int'(bus0.done), 0);
    d = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus0.done) d++;
    end
    check("midrst_no_done", d, 0);
    run_conv(0, 200, lat, bc, hb);
    check("postrst_lat", lat, 8);
    check("postrst_bcd", int'(bus0.bcd_out), 12'h200);

    // Reset together with start: start is taken on the first edge after reset.
    rst = 1'b1;
    drive(0, 1'b1, 5);
    @(negedge clk);
    check("rst_start_busy_during", int'(bus0.busy), 0);
    rst = 1'b0;
    @(negedge clk);
    drive(0, 1'b0, 5);
    check("rst_start_busy_after", int'(bus0.busy), 1);
    lat = 0;
    while (!bus0.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("rst_start_lat", lat, 8);
    check("rst_start_bcd", int'(bus0.bcd_out), 12'h005);

    // AUTO start on value change (reset above left last_val = 0).
    for (int step = 0; step < 4; step++) begin
      if (step == 1) bus1.binary_in = 8'd1;
      if (step == 2) bus1.binary_in = 8'd2;
      d = 0;
      repeat (20) begin
        @(negedge clk);
        if (bus1.done) d++;
      end
      check($sformatf("auto_dones_step%0d", step), d, (step == 1 || step == 2) ? 1 : 0);
      check($sformatf("auto_bcd_step%0d", step), int'(bus1.bcd_out),
            (step == 0) ? 0 : ((step == 1) ? 12'h001 : 12'h002));
    end

    // 10-bit input into 3 digits: overflow and truncation.
    run_conv(2, 1023, lat, bc, hb);
    check("w10_1023_lat", lat, 10);
    check("w10_1023_bcd", int'(bus2.bcd_out), 12'h023);
    check("w10_1023_ovf", int'(bus2.overflow), 1);
    run_conv(2, 999, lat, bc, hb);
    check("w10_999_lat", lat, 10);
    check("w10_999_bcd", int'(bus2.bcd_out), 12'h999);
    check("w10_999_ovf", int'(bus2.overflow), 0);
    run_conv(2, 1000, lat, bc, hb);
    check("w10_1000_bcd", int'(bus2.bcd_out), 12'h000);
    check("w10_1000_ovf", int'(bus2.overflow), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
